spart_tx: RTL and testbench

SPART_TX -- requirements
Module: spart_tx

---
 rtl/spart_pkg.sv | 21 ++
 rtl/spart_baud_gen.sv | 28 ++
 rtl/spart_tx.sv | 127 ++++++++++++
 tb/tb_spart_tx.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmitter (and its receiver peer).
package spart_pkg;

  typedef enum logic [1:0] {
    TRANSMIT_BUFFER = 2'b00,
    STATUS_REGISTER = 2'b01,
    DB_LOW          = 2'b10,
    DB_HIGH         = 2'b11
  } ioaddr_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // 9600 baud from a 50 MHz clock
  localparam logic [15:0] DIV_RESET = 16'd5208;

endpackage

// File: rtl/spart_baud_gen.sv
// Bit-period counter: pulses tick on the last clock of each D-clock bit period.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] reload;

  // A divisor of zero behaves as one so the period never collapses to nothing
  always_comb reload = (divisor == '0) ? '0 : divisor - 16'd1;

  assign tick = en && (cnt == '0);

  // Held at the reload value while disabled so the first period is a full D clocks
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (!en || tick)
      cnt <= reload;
    else
      cnt <= cnt - 16'd1;
  end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serializer with a programmable baud divisor.
module spart_tx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] wr_data,
  output logic       tbr,
  output logic       txd
);

  tx_state_e   state, next_state;
  ioaddr_e     sel;
  logic [15:0] divisor;
  logic [7:0]  buf_data;
  logic        buf_full;
  logic [7:0]  shift_reg, shift_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic        txd_d;
  logic        load;
  logic        tick;
  logic        wr_en;
  logic        wr_buf;

  assign sel    = ioaddr_e'(ioaddr);
  assign wr_en  = iocs && !iorw;
  // A write while the buffer is occupied (including the transfer cycle) is dropped
  assign wr_buf = wr_en && (sel == TRANSMIT_BUFFER) && !buf_full;
  assign tbr    = !buf_full;

  spart_baud_gen u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .divisor (divisor),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_d    = shift_reg;
    bit_cnt_d  = bit_cnt;
    txd_d      = txd;
    load       = 1'b0;
    case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (buf_full) begin
          load       = 1'b1;
          next_state = START;
          shift_d    = buf_data;
          txd_d      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          next_state = DATA;
          bit_cnt_d  = '0;
          txd_d      = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            next_state = STOP;
            txd_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
            shift_d   = {1'b0, shift_reg[7:1]};
            txd_d     = shift_reg[1];
          end
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          // Chain straight into the next frame when a byte is already waiting
          if (buf_full) begin
            load       = 1'b1;
            next_state = START;
            shift_d    = buf_data;
            txd_d      = 1'b0;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd       <= 1'b1;
      buf_full  <= 1'b0;
      buf_data  <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      divisor   <= DIV_RESET;
    end else begin
      txd       <= txd_d;
      shift_reg <= shift_d;
      bit_cnt   <= bit_cnt_d;
      if (wr_en && (sel == DB_LOW))
        divisor[7:0] <= wr_data;
      if (wr_en && (sel == DB_HIGH))
        divisor[15:8] <= wr_data;
      if (load) begin
        buf_full <= 1'b0;
      end else if (wr_buf) begin
        buf_full <= 1'b1;
        buf_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed self-checking bench for spart_tx: frame timing, double buffering, drops, reset abort.
module tb_spart_tx;

  logic       clk;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] wr_data;
  logic       tbr;
  logic       txd;

  int tests;
  int failed;

  spart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .wr_data (wr_data),
    .tbr     (tbr),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is captured by the following posedge.
  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    iocs    = 1'b1;
    iorw    = 1'b0;
    ioaddr  = a;
    wr_data = d;
    @(negedge clk);
    iocs = 1'b0;
    iorw = 1'b1;
  endtask

  // Sample s (from 0) is the s-th clock after the frame's start edge.
  task automatic frame(input logic [7:0] b, input int d, input int nsamp,
                       input int inj_at, input logic [7:0] inj_d,
                       input int inj2_at, input logic [7:0] inj2_d, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int s = 0; s < nsamp; s++) begin
      @(negedge clk);
      iocs = 1'b0;
      iorw = 1'b1;
      check($sformatf("%s txd s=%0d", tag, s), {31'd0, txd}, {31'd0, f[s / d]});
      if (s == 0)
        check($sformatf("%s tbr at start", tag), {31'd0, tbr}, 32'd1);
      if (inj_at >= 0 && s == inj_at + 1)
        check($sformatf("%s tbr after buffered write", tag), {31'd0, tbr}, 32'd0);
      if (s == inj_at || s == inj2_at) begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = 2'b00;
        wr_data = (s == inj_at) ? inj_d : inj2_d;
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s txd", tag), {31'd0, txd}, 32'd1);
      check($sformatf("%s tbr", tag), {31'd0, tbr}, 32'd1);
    end
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst     = 1'b1;
    iocs    = 1'b0;
    iorw    = 1'b1;
    ioaddr  = 2'b00;
    wr_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset tbr", {31'd0, tbr}, 32'd1);
    rst = 1'b0;
    idle_check(3, "post-reset idle");

    // Reads and deselected writes must not load the buffer
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; wr_data = 8'hFF;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
    @(negedge clk);
    iorw = 1'b1;
    idle_check(3, "read/no-cs ignored");

    // Divisor 4, single frame of A5
    write_reg(2'b10, 8'd4);
    write_reg(2'b11, 8'd0);
    write_reg(2'b00, 8'hA5);
    check("A5 tbr low", {31'd0, tbr}, 32'd0);
    check("A5 txd idle before start", {31'd0, txd}, 32'd1);
    frame(8'hA5, 4, 40, -1, 8'h00, -1, 8'h00, "A5");
    idle_check(5, "after A5");

    // Back-to-back 55 then 0F; 11 written while buffer is full is dropped
    write_reg(2'b00, 8'h55);
    check("55 tbr low", {31'd0, tbr}, 32'd0);
    frame(8'h55, 4, 40, 5, 8'h0F, 10, 8'h11, "55");
    frame(8'h0F, 4, 40, -1, 8'h00, -1, 8'h00, "0F");
    idle_check(50, "after 0F (11 dropped)");

    // Divisor 0 acts as 1: ten-clock frame
    write_reg(2'b10, 8'd0);
    write_reg(2'b00, 8'h96);
    check("96 tbr low", {31'd0, tbr}, 32'd0);
    frame(8'h96, 1, 10, -1, 8'h00, -1, 8'h00, "96 div0");
    idle_check(5, "after 96");

    // Reset during data bit 3 with a byte pending; both are discarded
    write_reg(2'b10, 8'd4);
    write_reg(2'b00, 8'hC3);
    frame(8'hC3, 4, 18, 2, 8'h99, -1, 8'h00, "C3 partial");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort txd", {31'd0, txd}, 32'd1);
    check("abort tbr", {31'd0, tbr}, 32'd1);
    idle_check(60, "after abort");

    // Divisor back at reset value
    write_reg(2'b00, 8'h3C);
    check("3C tbr low", {31'd0, tbr}, 32'd0);
    frame(8'h3C, 5208, 52080, -1, 8'h00, -1, 8'h00, "3C div5208");
    idle_check(5, "after 3C");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
